// File: rtl/dadda_product_accumulator_if.sv
// dadda_product_accumulator_if: product beat input and frame-sum result port bundle
interface dadda_product_accumulator_if #(parameter int ACC_W = 12);
  logic op_valid, clear, res_ready, res_valid, busy, ovf_err;
  logic [7:0] prod;
  logic [ACC_W-1:0] res_data;
  modport master (output op_valid, prod, clear, res_ready, input res_valid, res_data, busy, ovf_err);
  modport slave (input op_valid, prod, clear, res_ready, output res_valid, res_data, busy, ovf_err);
endinterface

// File: rtl/dadda_product_accumulator.sv
// dadda_product_accumulator: sums FRAME_LEN multiplier products per frame into a double-buffered result
module dadda_product_accumulator #(
  parameter int MUL_LAT = 2,
  parameter int FRAME_LEN = 16,
  parameter int ACC_W = 12
) (
  input logic clk,
  input logic reset,
  dadda_product_accumulator_if.slave bus
);
  localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_n;
  logic [MUL_LAT-1:0] vpipe, vpipe_n;
  logic [ACC_W-1:0] acc, acc_n, sum, res_data;
  logic [CW-1:0] cnt, cnt_n;
  logic beat, done, xfer, load, res_valid, ovf_err;
  always_comb begin
    vpipe_n = vpipe << 1;
    vpipe_n[0] = bus.op_valid;
    beat = vpipe[MUL_LAT-1];
    sum = acc + ACC_W'(bus.prod);
    done = beat && cnt == CW'(FRAME_LEN - 1);
    xfer = res_valid && bus.res_ready;
    load = done && !bus.clear && (!res_valid || xfer);
    state_n = bus.clear ? IDLE : beat ? (done ? IDLE : ACCUM) : state;
    acc_n = bus.clear || done ? '0 : beat ? sum : acc;
    cnt_n = bus.clear || done ? '0 : beat ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      vpipe <= '0;
      acc <= '0;
      cnt <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_n;
      vpipe <= bus.clear ? '0 : vpipe_n;
      acc <= acc_n;
      cnt <= cnt_n;
      res_valid <= load || (res_valid && !xfer);
      res_data <= load ? sum : res_data;
      ovf_err <= !bus.clear && (ovf_err || (done && res_valid && !xfer));
    end
  end
  assign bus.res_valid = res_valid;
  assign bus.res_data = res_data;
  assign bus.ovf_err = ovf_err;
  assign bus.busy = state == ACCUM || |vpipe;
endmodule

// File: tb/tb_dadda_product_accumulator.sv
// tb_dadda_product_accumulator: directed and random checks against a queue-based frame-sum model
module tb_dadda_product_accumulator;
  localparam int MUL_LAT = 2;
  localparam int FL = 4;
  logic clk = 0, reset = 1;
  logic op_valid = 0, clear = 0, res_ready = 0;
  logic [3:0] a = 0, b = 0, a_r = 0, b_r = 0;
  logic [7:0] prod_r = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, e0;
  bit run = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    a_r <= a;
    b_r <= b;
    prod_r <= 8'(a_r) * 8'(b_r);
  end
  dadda_product_accumulator_if #(.ACC_W(12)) ifa ();
  dadda_product_accumulator_if #(.ACC_W(12)) ifb ();
  assign ifa.op_valid = op_valid;
  assign ifa.prod = prod_r;
  assign ifa.clear = clear;
  assign ifa.res_ready = res_ready;
  assign ifb.op_valid = op_valid;
  assign ifb.prod = prod_r;
  assign ifb.clear = clear;
  assign ifb.res_ready = res_ready;
  dadda_product_accumulator #(.MUL_LAT(MUL_LAT), .FRAME_LEN(FL), .ACC_W(12)) u4 (.clk(clk), .reset(reset), .bus(ifa));
  dadda_product_accumulator #(.MUL_LAT(MUL_LAT), .FRAME_LEN(16), .ACC_W(12)) u16 (.clk(clk), .reset(reset), .bus(ifb));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  int q[$];
  int m_sum, m_cnt, m_rd;
  bit m_rv, m_ovf;
  always @(posedge clk or posedge reset) begin : model
    int arr, s;
    bit x, fin;
    if (reset) begin
      q = {};
      repeat (MUL_LAT) q.push_back(-1);
      m_sum = 0; m_cnt = 0; m_rd = 0; m_rv = 0; m_ovf = 0;
    end else begin
      arr = q.pop_front();
      x = m_rv && res_ready;
      if (clear) begin
        q = {};
        repeat (MUL_LAT) q.push_back(-1);
        m_sum = 0; m_cnt = 0; m_ovf = 0;
        if (x) m_rv = 0;
      end else begin
        q.push_back(op_valid ? int'(a) * int'(b) : -1);
        fin = 0;
        s = 0;
        if (arr >= 0) begin
          m_sum += arr;
          m_cnt++;
          if (m_cnt == FL) begin
            fin = 1; s = m_sum % 4096; m_sum = 0; m_cnt = 0;
          end
        end
        if (fin && (!m_rv || x)) begin
          m_rd = s; m_rv = 1;
        end else if (fin) m_ovf = 1;
        else if (x) m_rv = 0;
      end
    end
  end
  function automatic bit m_busy();
    foreach (q[i]) if (q[i] >= 0) return 1;
    return m_cnt > 0;
  endfunction
  always @(negedge clk) if (run) begin
    chk("rv", ifa.res_valid, m_rv);
    chk("rd", ifa.res_data, m_rd);
    chk("busy", ifa.busy, m_busy());
    chk("ovf", ifa.ovf_err, m_ovf);
  end
  task automatic step(input logic v, input logic [3:0] ia, input logic [3:0] ib, input logic rdy, input logic clr);
    @(negedge clk);
    #1;
    op_valid = v; a = ia; b = ib; res_ready = rdy; clear = clr;
  endtask
  task automatic wait_rv(input bit big, input logic rdy);
    for (int n = 0; n < 40 && !(big ? ifb.res_valid : ifa.res_valid); n++) step(0, 0, 0, rdy, 0);
  endtask
  initial begin
    logic [6:0] pat;
    repeat (2) @(negedge clk);
    chk("rst_rv", ifa.res_valid, 0);
    chk("rst_rd", ifa.res_data, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_ovf", ifa.ovf_err, 0);
    #1 reset = 0;
    run = 1;
    step(1, 3, 5, 1, 0);
    e0 = cyc;
    repeat (3) step(1, 3, 5, 1, 0);
    wait_rv(0, 1);
    chk("s1_seen", ifa.res_valid, 1);
    chk("s1_lat", cyc - e0, 6);
    chk("s1_data", ifa.res_data, 60);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("s1_pulse", ifa.res_valid, 0);
    step(0, 0, 0, 1, 1);
    repeat (16) step(1, 15, 15, 1, 0);
    wait_rv(1, 1);
    chk("s2_seen", ifb.res_valid, 1);
    chk("s2_data", ifb.res_data, 3600);
    chk("s2_ovf", ifb.ovf_err, 0);
    step(0, 0, 0, 1, 1);
    pat = 7'b1101001;
    for (int i = 0, k = 1; i < 7; i++) begin
      step(pat[i], 4'(k), 4'(k + 1), 1, 0);
      if (pat[i]) k++;
      if (i == 1) chk("s3_busy", ifa.busy, 1);
    end
    wait_rv(0, 1);
    chk("s3_data", ifa.res_data, 40);
    chk("s3_busy_end", ifa.busy, 0);
    step(0, 0, 0, 1, 1);
    repeat (8) step(1, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    chk("s4_rv", ifa.res_valid, 1);
    chk("s4_data", ifa.res_data, 4);
    chk("s4_ovf", ifa.ovf_err, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("s4_xfer", ifa.res_valid, 0);
    chk("s4_sticky", ifa.ovf_err, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("s4_clr", ifa.ovf_err, 0);
    step(0, 0, 0, 1, 1);
    repeat (4) step(1, 1, 1, 0, 0);
    repeat (4) step(1, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("s5_first", ifa.res_data, 4);
    step(0, 0, 0, 0, 0);
    chk("s5_rv", ifa.res_valid, 1);
    chk("s5_data", ifa.res_data, 8);
    chk("s5_ovf", ifa.ovf_err, 0);
    step(0, 0, 0, 1, 1);
    repeat (4) step(1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    chk("s6_norv", ifa.res_valid, 0);
    chk("s6_idle", ifa.busy, 0);
    repeat (4) step(1, 2, 2, 0, 0);
    wait_rv(0, 0);
    chk("s6_data", ifa.res_data, 16);
    repeat (2) step(1, 3, 3, 0, 0);
    #2 reset = 1;
    #1;
    chk("s6_rst_rv", ifa.res_valid, 0);
    chk("s6_rst_rd", ifa.res_data, 0);
    chk("s6_rst_busy", ifa.busy, 0);
    chk("s6_rst_ovf", ifa.ovf_err, 0);
    #1 reset = 0;
    repeat (500)
      step(1'($urandom_range(0, 99) < 60), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 3));
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
